// File: rtl/profibus_link.sv
// -----------------------------------------------------------------------------
// profibus_link
//   Master-side frame engine for a simple request/response field-bus link.
//   A request of up to DEPTH payload beats is buffered, then sent on the line
//   followed by an additive frame check sum (FCS) beat. The block then waits
//   for the slave's response. Response payload beats are forwarded one beat
//   late, so the final payload beat can be tagged rx_last when the response
//   FCS beat arrives. The response FCS beat itself is checked and discarded.
//
// Parameters
//   DATA_W  : width of every data beat and of the FCS
//   DEPTH   : max request payload beats (power of 2, >= 2)
//   TIMEOUT : response / inter-beat timeout in clk cycles (>= 2)
//
// Ports
//   clk_i, rst_ni                      : clock (rising edge), async active-low reset
//   tx_valid_i/tx_data_i/tx_last_i     : request beat in
//   tx_ready_o                         : request beat accepted when high
//   line_valid_o/line_data_o/line_last_o : outgoing line beats (last = FCS beat)
//   resp_valid_i/resp_data_i/resp_last_i : response beats from slave (last = FCS)
//   rx_valid_o/rx_data_o/rx_last_o     : delivered response payload beats
//   enable_o                           : high while driving the line
//   busy_o                             : high whenever not idle
//   err_timeout_o, err_fcs_o           : one-cycle error pulses
// -----------------------------------------------------------------------------
module profibus_link #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  output logic              tx_ready_o,
  output logic              line_valid_o,
  output logic [DATA_W-1:0] line_data_o,
  output logic              line_last_o,
  input  logic              resp_valid_i,
  input  logic [DATA_W-1:0] resp_data_i,
  input  logic              resp_last_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_last_o,
  output logic              enable_o,
  output logic              busy_o,
  output logic              err_timeout_o,
  output logic              err_fcs_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FCS_TX,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       rd_idx_q, rd_idx_d;
  logic [DATA_W-1:0]   fcs_q, fcs_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0]   rx_fcs_q, rx_fcs_d;

  logic                line_valid_q, line_valid_d;
  logic [DATA_W-1:0]   line_data_q, line_data_d;
  logic                line_last_q, line_last_d;
  logic                enable_q, enable_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_last_q, rx_last_d;
  logic                err_to_q, err_to_d;
  logic                err_fcs_q, err_fcs_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                tx_fire;
  logic [AW-1:0]       wr_addr;
  logic [AW-1:0]       rd_next;

  // tx_ready is held low while reset is asserted so nothing is accepted then.
  assign tx_ready_o = rst_ni &&
                      ((state_q == S_IDLE) ||
                       ((state_q == S_LOAD) && (cnt_q < CW'(DEPTH))));
  assign tx_fire    = tx_valid_i && tx_ready_o;
  assign wr_addr    = (state_q == S_IDLE) ? '0 : cnt_q[AW-1:0];
  assign rd_next    = rd_idx_q + AW'(1);

  // Payload buffer: no reset, contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (tx_fire) begin
      mem[wr_addr] <= tx_data_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_idx_d     = rd_idx_q;
    fcs_d        = fcs_q;
    timer_d      = timer_q;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    rx_fcs_d     = rx_fcs_q;
    line_valid_d = 1'b0;
    line_data_d  = '0;
    line_last_d  = 1'b0;
    enable_d     = 1'b0;
    rx_valid_d   = 1'b0;
    rx_data_d    = '0;
    rx_last_d    = 1'b0;
    err_to_d     = 1'b0;
    err_fcs_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        hold_vld_d = 1'b0;
        if (tx_fire) begin
          cnt_d = CW'(1);
          if (tx_last_i) begin
            // Single-beat frame: the beat is being written this cycle,
            // so it is forwarded straight to the line register.
            state_d      = S_SEND;
            rd_idx_d     = '0;
            fcs_d        = '0;
            line_valid_d = 1'b1;
            enable_d     = 1'b1;
            line_data_d  = tx_data_i;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (tx_fire) begin
          cnt_d = cnt_q + CW'(1);
          // The beat landing in the last slot closes the frame.
          if (tx_last_i || (cnt_q == CW'(DEPTH - 1))) begin
            state_d      = S_SEND;
            rd_idx_d     = '0;
            fcs_d        = '0;
            line_valid_d = 1'b1;
            enable_d     = 1'b1;
            line_data_d  = mem[0];
          end
        end
      end

      S_SEND: begin
        // line_data_q holds the beat on the line this cycle; fold it into FCS.
        fcs_d        = fcs_q + line_data_q;
        line_valid_d = 1'b1;
        enable_d     = 1'b1;
        if ({1'b0, rd_idx_q} == (cnt_q - CW'(1))) begin
          state_d     = S_FCS_TX;
          line_last_d = 1'b1;
          line_data_d = fcs_q + line_data_q;
        end else begin
          rd_idx_d    = rd_next;
          line_data_d = mem[rd_next];
        end
      end

      S_FCS_TX: begin
        state_d    = S_WAIT;
        timer_d    = '0;
        rx_fcs_d   = '0;
        hold_d     = '0;
        hold_vld_d = 1'b0;
      end

      S_WAIT: begin
        if (resp_valid_i) begin
          timer_d = '0;
          if (resp_last_i) begin
            state_d    = S_IDLE;
            rx_valid_d = hold_vld_q;
            rx_data_d  = hold_vld_q ? hold_q : '0;
            rx_last_d  = hold_vld_q;
            err_fcs_d  = (resp_data_i != rx_fcs_q);
            hold_vld_d = 1'b0;
          end else begin
            // A new payload beat releases the previously held one.
            rx_valid_d = hold_vld_q;
            rx_data_d  = hold_vld_q ? hold_q : '0;
            hold_d     = resp_data_i;
            hold_vld_d = 1'b1;
            rx_fcs_d   = rx_fcs_q + resp_data_i;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Held beat is dropped: a timed-out response is never completed.
          state_d    = S_IDLE;
          err_to_d   = 1'b1;
          hold_vld_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_idx_q     <= '0;
      fcs_q        <= '0;
      timer_q      <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      rx_fcs_q     <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      line_last_q  <= 1'b0;
      enable_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_last_q    <= 1'b0;
      err_to_q     <= 1'b0;
      err_fcs_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_idx_q     <= rd_idx_d;
      fcs_q        <= fcs_d;
      timer_q      <= timer_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      rx_fcs_q     <= rx_fcs_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      line_last_q  <= line_last_d;
      enable_q     <= enable_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      rx_last_q    <= rx_last_d;
      err_to_q     <= err_to_d;
      err_fcs_q    <= err_fcs_d;
    end
  end

  assign line_valid_o  = line_valid_q;
  assign line_data_o   = line_data_q;
  assign line_last_o   = line_last_q;
  assign enable_o      = enable_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign rx_last_o     = rx_last_q;
  assign err_timeout_o = err_to_q;
  assign err_fcs_o     = err_fcs_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_profibus_link.sv
// -----------------------------------------------------------------------------
// tb_profibus_link
//   Self-checking bench for profibus_link: directed scenarios plus randomized
//   frames checked against a frame-level model (payload list + additive sum).
// -----------------------------------------------------------------------------
module tb_profibus_link;

  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_last = 1'b0;
  logic          tx_ready;
  logic          line_valid;
  logic [DW-1:0] line_data;
  logic          line_last;
  logic          resp_valid = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic          resp_last = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_last;
  logic          enable;
  logic          busy;
  logic          err_timeout;
  logic          err_fcs;

  always #5 clk = ~clk;

  profibus_link #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tx_valid_i    (tx_valid),
    .tx_data_i     (tx_data),
    .tx_last_i     (tx_last),
    .tx_ready_o    (tx_ready),
    .line_valid_o  (line_valid),
    .line_data_o   (line_data),
    .line_last_o   (line_last),
    .resp_valid_i  (resp_valid),
    .resp_data_i   (resp_data),
    .resp_last_i   (resp_last),
    .rx_valid_o    (rx_valid),
    .rx_data_o     (rx_data),
    .rx_last_o     (rx_last),
    .enable_o      (enable),
    .busy_o        (busy),
    .err_timeout_o (err_timeout),
    .err_fcs_o     (err_fcs)
  );

  // Monitor: records every line / rx beat as {last, data} and counts pulses.
  logic [DW:0] line_q[$];
  logic [DW:0] rx_q[$];
  int          fcs_err_cnt = 0;
  int          to_cnt      = 0;
  int          en_cnt      = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (line_valid) line_q.push_back({line_last, line_data});
      if (rx_valid)   rx_q.push_back({rx_last, rx_data});
      if (err_fcs)     fcs_err_cnt++;
      if (err_timeout) to_cnt++;
      if (enable)      en_cnt++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] tx_pl [32];
  logic [DW-1:0] rs_pl [32];

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic drive_tx(input int n, input bit lf, output int acc, output logic rdy_stop);
    acc      = 0;
    rdy_stop = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = tx_pl[i];
      tx_last  = lf && (i == n - 1);
      #1;
      if (!tx_ready) begin
        rdy_stop = 1'b0;
        break;
      end
      @(posedge clk);
      acc++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
  endtask

  task automatic wait_line_last(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (line_valid && line_last) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_resp(input int n, input bit lf, input int gapmax);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      resp_valid = 1'b1;
      resp_data  = rs_pl[i];
      resp_last  = lf && (i == n - 1);
      g = $urandom_range(0, gapmax);
      for (int k = 0; k < g; k++) begin
        @(negedge clk);
        resp_valid = 1'b0;
        resp_last  = 1'b0;
      end
    end
    @(negedge clk);
    resp_valid = 1'b0;
    resp_last  = 1'b0;
    resp_data  = '0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_frame(input int ntx, input bit tlf, input int nrs, input bit rlf,
                          input int gapmax, output int acc, output logic rdy, output bit ok);
    bit ok1, ok2;
    drive_tx(ntx, tlf, acc, rdy);
    wait_line_last(ok1);
    if (nrs > 0) drive_resp(nrs, rlf, gapmax);
    wait_idle(ok2);
    ok = ok1 && ok2;
  endtask

  // ---------------------------- tests ----------------------------
  task automatic test_reset();
    logic [DW*3+10:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {tx_ready, line_valid, line_last, line_data, rx_valid, rx_last, rx_data,
            enable, busy, err_timeout, err_fcs, 2'b00};
    n_cmp++;
    if (outs !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %0h expected 0", outs);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({tx_ready, busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: got ready/busy=%b expected 10", {tx_ready, busy});
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int acc, lb, rb, fb, eb;
    logic rdy;
    bit ok;
    logic [DW:0] exp_line [4];
    logic [DW:0] exp_rx [2];
    tx_pl[0] = 8'h10; tx_pl[1] = 8'h20; tx_pl[2] = 8'h30;
    rs_pl[0] = 8'hAA; rs_pl[1] = 8'h01; rs_pl[2] = 8'hAB;
    exp_line[0] = 9'h010; exp_line[1] = 9'h020; exp_line[2] = 9'h030; exp_line[3] = 9'h160;
    exp_rx[0] = 9'h0AA; exp_rx[1] = 9'h101;
    lb = line_q.size(); rb = rx_q.size(); fb = fcs_err_cnt; eb = en_cnt;
    do_frame(3, 1'b1, 3, 1'b1, 0, acc, rdy, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_done: got timeout expected completion"); end
    n_cmp++;
    if (line_q.size() - lb != 4) begin
      n_bad++; $display("FAIL basic_line_cnt: got %0d expected 4", line_q.size() - lb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (line_q[lb + i] !== exp_line[i]) begin
          n_bad++; $display("FAIL basic_line[%0d]: got %0h expected %0h", i, line_q[lb + i], exp_line[i]);
        end
      end
    end
    n_cmp++;
    if (en_cnt - eb != 4) begin n_bad++; $display("FAIL basic_enable: got %0d cycles expected 4", en_cnt - eb); end
    n_cmp++;
    if (rx_q.size() - rb != 2) begin
      n_bad++; $display("FAIL basic_rx_cnt: got %0d expected 2", rx_q.size() - rb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (rx_q[rb + i] !== exp_rx[i]) begin
          n_bad++; $display("FAIL basic_rx[%0d]: got %0h expected %0h", i, rx_q[rb + i], exp_rx[i]);
        end
      end
    end
    n_cmp++;
    if (fcs_err_cnt != fb || busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_status: got fcs_err=%0d busy=%b expected 0 0", fcs_err_cnt - fb, busy);
    end
    $display("test_basic done");
  endtask

  task automatic test_fcs_err();
    int acc, lb, rb, fb;
    logic rdy;
    bit ok;
    tx_pl[0] = 8'hFF; tx_pl[1] = 8'h02;
    rs_pl[0] = 8'h05; rs_pl[1] = 8'h07;
    lb = line_q.size(); rb = rx_q.size(); fb = fcs_err_cnt;
    do_frame(2, 1'b1, 2, 1'b1, 0, acc, rdy, ok);
    n_cmp++;
    if (!ok || line_q.size() - lb != 3) begin
      n_bad++; $display("FAIL fcs_line_cnt: got %0d ok=%b expected 3", line_q.size() - lb, ok);
    end else begin
      n_cmp++;
      if (line_q[lb + 2] !== 9'h101) begin
        n_bad++; $display("FAIL fcs_tx_value: got %0h expected 101", line_q[lb + 2]);
      end
    end
    n_cmp++;
    if (rx_q.size() - rb != 1 || rx_q[rx_q.size() - 1] !== 9'h105) begin
      n_bad++; $display("FAIL fcs_rx: got cnt=%0d expected 1 beat 105", rx_q.size() - rb);
    end
    n_cmp++;
    if (fcs_err_cnt - fb != 1) begin
      n_bad++; $display("FAIL fcs_err_pulse: got %0d expected 1", fcs_err_cnt - fb);
    end
    $display("test_fcs_err done");
  endtask

  task automatic test_timeout();
    int acc, seen_at, pulses;
    logic rdy, busy_after;
    bit ok;
    tx_pl[0] = 8'h5A;
    drive_tx(1, 1'b1, acc, rdy);
    wait_line_last(ok);
    seen_at = -1; pulses = 0; busy_after = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (err_timeout) begin
        pulses++;
        if (seen_at < 0) seen_at = k;
      end
      if (k == 66) busy_after = busy;
    end
    // k counts cycles from the FCS beat; WAIT is entered at k=1.
    n_cmp++;
    if (seen_at != TIMEOUT + 1) begin
      n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", seen_at - 1, TIMEOUT);
    end
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL timeout_width: got %0d expected 1", pulses); end
    n_cmp++;
    if (busy_after !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b expected 0", busy_after); end
    $display("test_timeout done");
  endtask

  task automatic test_overflow();
    int acc, lb, tb0;
    logic rdy;
    bit ok;
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < 17; i++) begin
      tx_pl[i] = DW'($urandom);
      if (i < DEPTH) sum = sum + tx_pl[i];
    end
    lb = line_q.size(); tb0 = to_cnt;
    do_frame(17, 1'b0, 0, 1'b0, 0, acc, rdy, ok);
    n_cmp++;
    if (acc != DEPTH || rdy !== 1'b0) begin
      n_bad++; $display("FAIL ovf_accept: got %0d ready=%b expected %0d 0", acc, rdy, DEPTH);
    end
    n_cmp++;
    if (line_q.size() - lb != DEPTH + 1) begin
      n_bad++; $display("FAIL ovf_line_cnt: got %0d expected %0d", line_q.size() - lb, DEPTH + 1);
    end else begin
      for (int i = 0; i <= DEPTH; i++) begin
        logic [DW:0] e;
        e = (i == DEPTH) ? {1'b1, sum} : {1'b0, tx_pl[i]};
        n_cmp++;
        if (line_q[lb + i] !== e) begin
          n_bad++; $display("FAIL ovf_line[%0d]: got %0h expected %0h", i, line_q[lb + i], e);
        end
      end
    end
    n_cmp++;
    if (!ok || to_cnt - tb0 != 1) begin
      n_bad++; $display("FAIL ovf_timeout: got %0d ok=%b expected 1", to_cnt - tb0, ok);
    end
    $display("test_overflow done");
  endtask

  task automatic test_reset_mid();
    int acc, lb, rb, fb;
    logic rdy;
    bit ok;
    for (int i = 0; i < 5; i++) tx_pl[i] = DW'(8'h40 + i);
    drive_tx(5, 1'b1, acc, rdy);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({line_valid, busy, enable, tx_ready} !== 4'b0000) begin
      n_bad++; $display("FAIL midrst_outputs: got %b expected 0000", {line_valid, busy, enable, tx_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    lb = line_q.size(); rb = rx_q.size();
    repeat (10) @(negedge clk);
    n_cmp++;
    if (line_q.size() != lb || rx_q.size() != rb) begin
      n_bad++; $display("FAIL midrst_residue: got %0d line %0d rx beats expected 0 0",
                        line_q.size() - lb, rx_q.size() - rb);
    end
    // Follow-up frame with an FCS-only response (0x05 vs sum 0): error, no rx.
    tx_pl[0] = 8'h03; tx_pl[1] = 8'h04; rs_pl[0] = 8'h05;
    fb = fcs_err_cnt;
    do_frame(2, 1'b1, 1, 1'b1, 0, acc, rdy, ok);
    n_cmp++;
    if (!ok || line_q.size() - lb != 3) begin
      n_bad++; $display("FAIL midrst_next_cnt: got %0d expected 3", line_q.size() - lb);
    end else begin
      n_cmp++;
      if ({line_q[lb], line_q[lb + 1], line_q[lb + 2]} !== {9'h003, 9'h004, 9'h107}) begin
        n_bad++; $display("FAIL midrst_next_data: got %0h %0h %0h expected 3 4 107",
                          line_q[lb], line_q[lb + 1], line_q[lb + 2]);
      end
    end
    n_cmp++;
    if (rx_q.size() != rb || fcs_err_cnt - fb != 1) begin
      n_bad++; $display("FAIL fcs_only: got rx=%0d err=%0d expected 0 1", rx_q.size() - rb, fcs_err_cnt - fb);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_ignore();
    int rb, fb, tb0;
    rb = rx_q.size(); fb = fcs_err_cnt; tb0 = to_cnt;
    for (int i = 0; i < 3; i++) rs_pl[i] = DW'($urandom);
    drive_resp(3, 1'b1, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx_q.size() != rb || fcs_err_cnt != fb || to_cnt != tb0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_resp_ignored: got rx=%0d err=%0d busy=%b expected 0 0 0",
                        rx_q.size() - rb, fcs_err_cnt - fb, busy);
    end
    $display("test_ignore done");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int ntx, np, kind, eff, acc, lb, rb, fb, tb0, exp_rx_n;
      bit tlf, has_last, ok, exp_err;
      logic rdy;
      logic [DW-1:0] sum, rsum;
      logic [DW:0] e;
      if ($urandom_range(0, 3) == 0) begin
        ntx = $urandom_range(DEPTH + 1, DEPTH + 4); tlf = 1'b0;
      end else begin
        ntx = $urandom_range(1, DEPTH); tlf = 1'b1;
      end
      for (int i = 0; i < ntx; i++) tx_pl[i] = DW'($urandom);
      eff = (ntx > DEPTH) ? DEPTH : ntx;
      sum = '0;
      for (int i = 0; i < eff; i++) sum = sum + tx_pl[i];
      kind = $urandom_range(0, 2);
      has_last = (kind != 2);
      np = (kind == 2) ? $urandom_range(1, 4) : $urandom_range(0, 5);
      rsum = '0;
      for (int i = 0; i < np; i++) begin
        rs_pl[i] = DW'($urandom);
        rsum = rsum + rs_pl[i];
      end
      rs_pl[np] = (kind == 1) ? rsum + DW'($urandom_range(1, 255)) : rsum;
      exp_err  = (kind == 1);
      exp_rx_n = has_last ? np : np - 1;
      lb = line_q.size(); rb = rx_q.size(); fb = fcs_err_cnt; tb0 = to_cnt;
      do_frame(ntx, tlf, np + (has_last ? 1 : 0), has_last, 3, acc, rdy, ok);
      $display("rand frame %0d: tx=%0d resp=%0d kind=%0d", it, ntx, np, kind);
      n_cmp++;
      if (!ok || line_q.size() - lb != eff + 1) begin
        n_bad++; $display("FAIL rand%0d_line_cnt: got %0d expected %0d", it, line_q.size() - lb, eff + 1);
      end else begin
        for (int i = 0; i <= eff; i++) begin
          e = (i == eff) ? {1'b1, sum} : {1'b0, tx_pl[i]};
          n_cmp++;
          if (line_q[lb + i] !== e) begin
            n_bad++; $display("FAIL rand%0d_line[%0d]: got %0h expected %0h", it, i, line_q[lb + i], e);
          end
        end
      end
      n_cmp++;
      if (rx_q.size() - rb != exp_rx_n) begin
        n_bad++; $display("FAIL rand%0d_rx_cnt: got %0d expected %0d", it, rx_q.size() - rb, exp_rx_n);
      end else begin
        for (int i = 0; i < exp_rx_n; i++) begin
          e = {has_last && (i == np - 1), rs_pl[i]};
          n_cmp++;
          if (rx_q[rb + i] !== e) begin
            n_bad++; $display("FAIL rand%0d_rx[%0d]: got %0h expected %0h", it, i, rx_q[rb + i], e);
          end
        end
      end
      n_cmp++;
      if (fcs_err_cnt - fb != int'(exp_err) || to_cnt - tb0 != int'(!has_last)) begin
        n_bad++; $display("FAIL rand%0d_errs: got fcs=%0d to=%0d expected %0d %0d",
                          it, fcs_err_cnt - fb, to_cnt - tb0, exp_err, !has_last);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fcs_err();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_ignore();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
